program_memory_loader: RTL and testbench

//   64x8 RAM serving the adding-machine CPU's address/data buses, plus a byte-stream loader that fills it before execution.

---
 rtl/program_memory_loader.sv | 99 +++++++++
 tb/tb_program_memory_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader.sv
// 64x8 program RAM for the adding-machine CPU with a byte-stream loader.
// The loader parks the CPU via cpu_hold, fills ascending addresses and reports a mod-2**DATA_W checksum.
module program_memory_loader #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int LOAD_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr_bus,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [DATA_W-1:0] data_bus_out,
  output logic [DATA_W-1:0] data_bus_in,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_sum,
  output logic              cpu_hold
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              ld_xfer;
  logic              cpu_wr;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ld_xfer = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          ld_xfer = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          sum_d   = sum_q + ld_data;
          if (cnt_q == LAST_ADDR) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  assign cpu_hold = (state_q != IDLE);
  assign ld_ready = (state_q == LOAD);
  assign ld_done  = (state_q == DONE);
  assign ld_sum   = sum_q;
  assign cpu_wr   = wr_mem && !cpu_hold;

  // NOTE: the RAM has no reset so it maps onto plain memory and a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (ld_xfer) begin
      mem[cnt_q] <= ld_data;
    end else if (cpu_wr) begin
      mem[adr_bus] <= data_bus_out;
    end
  end

  // Read path is asynchronous, so a same-cycle read/write returns the old word.
  assign data_bus_in = (rd_mem && !cpu_hold) ? mem[adr_bus] : '0;

endmodule

// File: tb/tb_program_memory_loader.sv
// Randomized bench for program_memory_loader: a count/queue-level model of the load protocol
// and the CPU port is compared against the DUT every cycle, plus hand-computed spot checks.
module tb_program_memory_loader;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 8;
  localparam int LOAD_LEN = 64;
  localparam int DEPTH    = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] adr_bus = '0;
  logic              rd_mem = 1'b0;
  logic              wr_mem = 1'b0;
  logic [DATA_W-1:0] data_bus_out = '0;
  logic [DATA_W-1:0] data_bus_in;
  logic              ld_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_ready;
  logic              ld_done;
  logic [DATA_W-1:0] ld_sum;
  logic              cpu_hold;

  program_memory_loader #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LOAD_LEN(LOAD_LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .adr_bus     (adr_bus),
    .rd_mem      (rd_mem),
    .wr_mem      (wr_mem),
    .data_bus_out(data_bus_out),
    .data_bus_in (data_bus_in),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .ld_sum      (ld_sum),
    .cpu_hold    (cpu_hold)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a loading flag, a byte count, a running sum and an image of the RAM.
  bit                m_loading = 1'b0;
  bit                m_done = 1'b0;
  int                m_cnt = 0;
  logic [DATA_W-1:0] m_sum = '0;
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_known [DEPTH];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_loading <= 1'b0;
      m_done    <= 1'b0;
      m_cnt     <= 0;
      m_sum     <= '0;
    end else if (m_loading) begin
      if (ld_valid) begin
        m_mem[m_cnt % DEPTH]   <= ld_data;
        m_known[m_cnt % DEPTH] <= 1'b1;
        m_sum                  <= m_sum + ld_data;
        m_cnt                  <= m_cnt + 1;
        if (m_cnt + 1 == LOAD_LEN) begin
          m_loading <= 1'b0;
          m_done    <= 1'b1;
        end
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else begin
      if (wr_mem) begin
        m_mem[adr_bus]   <= data_bus_out;
        m_known[adr_bus] <= 1'b1;
      end
      if (ld_start) begin
        m_loading <= 1'b1;
        m_cnt     <= 0;
        m_sum     <= '0;
      end
    end
  end

  // Compare process: inputs change on the falling edge, outputs are checked 3 time units later.
  always begin
    @(negedge clk);
    #3;
    check("cpu_hold", cpu_hold, m_loading || m_done);
    check("ld_ready", ld_ready, m_loading);
    check("ld_done", ld_done, m_done);
    check("ld_sum", ld_sum, m_sum);
    if (m_loading || m_done || !rd_mem) check("data_bus_in_idle", data_bus_in, '0);
    else if (m_known[adr_bus]) check("data_bus_in", data_bus_in, m_mem[adr_bus]);
    if (ld_done) done_count++;
  end

  task automatic idle_in();
    rd_mem   = 1'b0;
    wr_mem   = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    idle_in();
    wr_mem = 1'b1;
    adr_bus = a;
    data_bus_out = d;
  endtask

  task automatic cpu_read_check(input string name, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] exp);
    @(negedge clk);
    idle_in();
    rd_mem = 1'b1;
    adr_bus = a;
    #3;
    check(name, data_bus_in, exp);
  endtask

  task automatic start_load();
    @(negedge clk);
    idle_in();
    ld_start = 1'b1;
  endtask

  // Streams bytes with random gaps until LOAD_LEN have been offered; returns their sum.
  task automatic random_load(input bit cpu_noise, input bit start_noise,
                             output int sent, output logic [DATA_W-1:0] sum);
    int iter;
    sent = 0;
    sum = '0;
    iter = 0;
    while (sent < LOAD_LEN && iter < 2000) begin
      @(negedge clk);
      idle_in();
      if (cpu_noise) begin
        rd_mem = 1'($urandom);
        wr_mem = 1'($urandom);
        adr_bus = ADDR_W'($urandom);
        data_bus_out = DATA_W'($urandom);
      end
      if (start_noise) ld_start = ($urandom_range(0, 2) == 0);
      ld_valid = (iter < 3) ? (iter != 1) : 1'($urandom);
      ld_data = DATA_W'($urandom);
      if (ld_valid) begin
        sent++;
        sum = sum + ld_data;
      end
      iter++;
    end
  endtask

  initial begin
    int d0;
    int sent;
    logic [DATA_W-1:0] drv_sum;

    #1 reset = 1'b0;
    #20;
    @(negedge clk);
    reset = 1'b1;

    // Pre-write RAM through the CPU port, then reset: outputs clear, RAM keeps its data.
    for (int i = 0; i < DEPTH; i++) cpu_write(ADDR_W'(i), DATA_W'($urandom));
    cpu_write(6'h2A, 8'h5C);
    @(negedge clk);
    idle_in();
    reset = 1'b0;
    #1;
    check("rst_cpu_hold", cpu_hold, 1'b0);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_ld_done", ld_done, 1'b0);
    check("rst_ld_sum", ld_sum, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    cpu_read_check("ram_kept_after_reset", 6'h2A, 8'h5C);

    // Back-to-back load of 0x00..0x3F.
    d0 = done_count;
    start_load();
    for (int k = 0; k < LOAD_LEN; k++) begin
      @(negedge clk);
      idle_in();
      ld_valid = 1'b1;
      ld_data = DATA_W'(k);
    end
    @(negedge clk);
    idle_in();
    #3;
    check("seq_done_pulse", ld_done, 1'b1);
    check("seq_sum", ld_sum, 8'hE0);
    check("seq_hold_in_done", cpu_hold, 1'b1);
    @(negedge clk);
    #3;
    check("seq_done_one_cycle", ld_done, 1'b0);
    check("seq_hold_released", cpu_hold, 1'b0);
    cpu_read_check("seq_read_15", 6'h15, 8'h15);
    check("seq_done_count", done_count - d0, 1);

    // Load with gaps (1-0-1 first) and CPU strobes that must be ignored.
    start_load();
    random_load(1'b1, 1'b0, sent, drv_sum);
    check("gap_load_complete", sent, LOAD_LEN);
    @(negedge clk);
    idle_in();
    #3;
    check("gap_done_pulse", ld_done, 1'b1);
    check("gap_sum", ld_sum, drv_sum);

    // CPU write/read at the top address.
    cpu_write(6'h3F, 8'hA5);
    cpu_read_check("cpu_rd_3f", 6'h3F, 8'hA5);

    // Partial load of 10 bytes, held CPU write to 0x3F, then reset mid-load.
    start_load();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      idle_in();
      ld_valid = 1'b1;
      ld_data = DATA_W'(k * 7 + 3);
      wr_mem = 1'b1;
      adr_bus = 6'h3F;
      data_bus_out = 8'h11;
    end
    @(negedge clk);
    idle_in();
    wr_mem = 1'b1;
    adr_bus = 6'h3F;
    data_bus_out = 8'h11;
    @(negedge clk);
    idle_in();
    #2 reset = 1'b0;
    #1;
    check("abort_hold_async", cpu_hold, 1'b0);
    check("abort_sum_cleared", ld_sum, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++)
      cpu_read_check("abort_bytes_kept", ADDR_W'(k), DATA_W'(k * 7 + 3));
    cpu_read_check("held_write_ignored", 6'h3F, 8'hA5);

    // ld_start pulses during LOAD and DONE are ignored.
    d0 = done_count;
    start_load();
    random_load(1'b0, 1'b1, sent, drv_sum);
    check("restart_load_complete", sent, LOAD_LEN);
    @(negedge clk);
    idle_in();
    ld_start = 1'b1;
    #3;
    check("restart_done_pulse", ld_done, 1'b1);
    check("restart_sum", ld_sum, drv_sum);
    @(negedge clk);
    idle_in();
    ld_valid = 1'b1;
    ld_data = 8'hFF;
    #3;
    check("restart_no_reload", ld_ready, 1'b0);
    check("restart_hold_low", cpu_hold, 1'b0);
    @(negedge clk);
    idle_in();
    #4;
    check("restart_one_done", done_count - d0, 1);

    // Mixed random traffic.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      idle_in();
      rd_mem = 1'($urandom);
      wr_mem = 1'($urandom);
      adr_bus = ADDR_W'($urandom);
      data_bus_out = DATA_W'($urandom);
      ld_start = ($urandom_range(0, 39) == 0);
      ld_valid = 1'($urandom);
      ld_data = DATA_W'($urandom);
    end

    @(negedge clk);
    idle_in();
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
